// File: rtl/guess_turn_ctrl.sv
// Turn controller for the two-player number-guessing judge: digit entry, compare, window narrowing, turn passing.
// Optional entry timeout enabled by defining GUESS_TIMEOUT_EN.
module guess_turn_ctrl #(
    parameter int MAX_ATTEMPTS  = 7,
    parameter int HOLD_TICKS    = 4,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [6:0] secret,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    output logic [2:0] state,
    output logic       player,
    output logic [7:0] guess_bcd,
    output logic [6:0] left,
    output logic [6:0] right,
    output logic [3:0] attempts0,
    output logic [3:0] attempts1,
    output logic [1:0] winner,
    output logic       hit,
    output logic       out_of_range,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_CHECK  = 3'd2,
        S_RESULT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int CNT_MAX = (HOLD_TICKS > TIMEOUT_TICKS) ? HOLD_TICKS : TIMEOUT_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);
    localparam logic [7:0] BLANK = 8'hBB;

    state_t st, st_n;
    logic          player_n;
    logic [7:0]    guess_n;
    logic [1:0]    dcnt, dcnt_n;
    logic [6:0]    left_n, right_n;
    logic [3:0]    a0_n, a1_n;
    logic [1:0]    winner_n;
    logic [6:0]    secret_q, secret_n;
    logic [CW-1:0] tcnt, tcnt_n;
    logic          hit_n, oor_n, to_n;
    logic          turn_end;
    logic [3:0]    tens_v, ones_v;
    logic [6:0]    value;

    function automatic logic [3:0] inc_sat(input logic [3:0] a);
        return (a == 4'd15) ? 4'd15 : a + 4'd1;
    endfunction

    assign state = st;

    // A blank (or any non-decimal) nibble contributes 0 to the guessed value.
    always_comb begin
        tens_v = (guess_bcd[7:4] > 4'd9) ? 4'd0 : guess_bcd[7:4];
        ones_v = (guess_bcd[3:0] > 4'd9) ? 4'd0 : guess_bcd[3:0];
        value  = {3'b000, tens_v} * 7'd10 + {3'b000, ones_v};
    end

    always_comb begin
        st_n     = st;
        player_n = player;
        guess_n  = guess_bcd;
        dcnt_n   = dcnt;
        left_n   = left;
        right_n  = right;
        a0_n     = attempts0;
        a1_n     = attempts1;
        winner_n = winner;
        secret_n = secret_q;
        tcnt_n   = tcnt;
        hit_n    = 1'b0;
        oor_n    = 1'b0;
        to_n     = 1'b0;
        turn_end = 1'b0;

        case (st)
            S_IDLE, S_DONE: begin
                if (start && secret >= 7'd1 && secret <= 7'd98) begin
                    secret_n = secret;
                    left_n   = 7'd0;
                    right_n  = 7'd99;
                    a0_n     = 4'd0;
                    a1_n     = 4'd0;
                    player_n = 1'b0;
                    winner_n = 2'b00;
                    guess_n  = BLANK;
                    dcnt_n   = 2'd0;
                    st_n     = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear) begin
                    guess_n = BLANK;
                    dcnt_n  = 2'd0;
                    tcnt_n  = '0;
                end else if (enter && dcnt != 2'd0) begin
                    st_n = S_CHECK;
                end else if (digit_valid) begin
                    tcnt_n = '0;
                    if (digit <= 4'd9) begin
                        guess_n = {guess_bcd[3:0], digit};
                        if (dcnt != 2'd2) dcnt_n = dcnt + 2'd1;
                    end
                end
`ifdef GUESS_TIMEOUT_EN
                else if (tick) begin
                    if (tcnt == CW'(TIMEOUT_TICKS - 1)) begin
                        to_n     = 1'b1;
                        guess_n  = BLANK;
                        dcnt_n   = 2'd0;
                        tcnt_n   = '0;
                        turn_end = 1'b1;
                        if (player) a1_n = inc_sat(attempts1);
                        else        a0_n = inc_sat(attempts0);
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
`endif
            end
            S_CHECK: begin
                if (player) a1_n = inc_sat(attempts1);
                else        a0_n = inc_sat(attempts0);
                if (value == secret_q) begin
                    left_n   = secret_q;
                    right_n  = secret_q;
                    winner_n = player ? 2'b10 : 2'b01;
                    hit_n    = 1'b1;
                    st_n     = S_DONE;
                end else if (value > left && value < right) begin
                    if (value < secret_q) left_n = value;
                    else                  right_n = value;
                    st_n = S_RESULT;
                end else begin
                    oor_n = 1'b1;
                    st_n  = S_RESULT;
                end
            end
            S_RESULT: begin
                if (tick) begin
                    if (tcnt == CW'(HOLD_TICKS - 1)) begin
                        guess_n  = BLANK;
                        dcnt_n   = 2'd0;
                        turn_end = 1'b1;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            default: st_n = S_IDLE;
        endcase

        // End of a turn: draw when both are exhausted, otherwise hand over unless the other player is out.
        if (turn_end) begin
            if (a0_n >= MAX_A && a1_n >= MAX_A) begin
                winner_n = 2'b11;
                st_n     = S_DONE;
            end else begin
                if ((player ? a0_n : a1_n) < MAX_A) player_n = ~player;
                st_n = S_ENTRY;
            end
        end

        if (st_n != st || player_n != player) tcnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= S_IDLE;
            player       <= 1'b0;
            guess_bcd    <= BLANK;
            dcnt         <= 2'd0;
            left         <= 7'd0;
            right        <= 7'd99;
            attempts0    <= 4'd0;
            attempts1    <= 4'd0;
            winner       <= 2'b00;
            secret_q     <= 7'd0;
            tcnt         <= '0;
            hit          <= 1'b0;
            out_of_range <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            st           <= st_n;
            player       <= player_n;
            guess_bcd    <= guess_n;
            dcnt         <= dcnt_n;
            left         <= left_n;
            right        <= right_n;
            attempts0    <= a0_n;
            attempts1    <= a1_n;
            winner       <= winner_n;
            secret_q     <= secret_n;
            tcnt         <= tcnt_n;
            hit          <= hit_n;
            out_of_range <= oor_n;
            timeout      <= to_n;
        end
    end

endmodule

// File: tb/tb_guess_turn_ctrl.sv
// Bench for guess_turn_ctrl: directed game walk-through followed by random play against a behavioural model.
module tb_guess_turn_ctrl;

  localparam int MAXA = 3;
  localparam int HOLD = 4;
  localparam int TMO  = 6;

  logic       clk, rst, tick, start, digit_valid, enter, clear;
  logic [6:0] secret;
  logic [3:0] digit;
  logic [2:0] state;
  logic       player, hit, out_of_range, timeout;
  logic [7:0] guess_bcd;
  logic [6:0] left, right;
  logic [3:0] attempts0, attempts1;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass   = 0;

  guess_turn_ctrl #(.MAX_ATTEMPTS(MAXA), .HOLD_TICKS(HOLD), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .secret(secret),
    .digit_valid(digit_valid), .digit(digit), .enter(enter), .clear(clear),
    .state(state), .player(player), .guess_bcd(guess_bcd), .left(left), .right(right),
    .attempts0(attempts0), .attempts1(attempts1), .winner(winner), .hit(hit),
    .out_of_range(out_of_range), .timeout(timeout)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: game rules over plain ints and a queue of entered digits
  int m_st, m_pl, m_left, m_right, m_win, m_sec, m_ticks;
  int m_att[2];
  int m_keys[$];
  bit m_hit, m_oor, m_to;

  function automatic int m_value();
    if (m_keys.size() == 2) return m_keys[0] * 10 + m_keys[1];
    if (m_keys.size() == 1) return m_keys[0];
    return 0;
  endfunction

  function automatic logic [7:0] m_guess();
    logic [7:0] g;
    g = 8'hBB;
    if (m_keys.size() == 1) g = 8'hB0 | 8'(m_keys[0]);
    if (m_keys.size() == 2) g = 8'(m_keys[0] * 16 + m_keys[1]);
    return g;
  endfunction

  task automatic m_end_turn();
    if (m_att[0] >= MAXA && m_att[1] >= MAXA) begin
      m_win = 3;
      m_st  = 4;
    end else begin
      if (m_att[1 - m_pl] < MAXA) m_pl = 1 - m_pl;
      m_st = 1;
    end
    m_ticks = 0;
  endtask

  task automatic m_bump();
    if (m_att[m_pl] < 15) m_att[m_pl]++;
  endtask

  task automatic model_step();
    int old_st, old_pl, v;
    m_hit = 0; m_oor = 0; m_to = 0;
    if (rst) begin
      m_st = 0; m_pl = 0; m_left = 0; m_right = 99; m_win = 0; m_sec = 0; m_ticks = 0;
      m_att[0] = 0; m_att[1] = 0;
      m_keys.delete();
      return;
    end
    old_st = m_st;
    old_pl = m_pl;
    case (m_st)
      0, 4: if (start && secret >= 1 && secret <= 98) begin
        m_sec = int'(secret); m_left = 0; m_right = 99; m_att[0] = 0; m_att[1] = 0;
        m_pl = 0; m_win = 0; m_keys.delete(); m_st = 1;
      end
      1: begin
        if (clear) begin
          m_keys.delete(); m_ticks = 0;
        end else if (enter && m_keys.size() > 0) begin
          m_st = 2;
        end else if (digit_valid) begin
          m_ticks = 0;
          if (digit <= 9) begin
            m_keys.push_back(int'(digit));
            if (m_keys.size() > 2) void'(m_keys.pop_front());
          end
        end
`ifdef GUESS_TIMEOUT_EN
        else if (tick) begin
          m_ticks++;
          if (m_ticks == TMO) begin
            m_to = 1; m_bump(); m_keys.delete(); m_end_turn();
          end
        end
`endif
      end
      2: begin
        v = m_value();
        m_bump();
        if (v == m_sec) begin
          m_left = m_sec; m_right = m_sec; m_win = m_pl + 1; m_hit = 1; m_st = 4;
        end else if (v > m_left && v < m_right) begin
          if (v < m_sec) m_left = v; else m_right = v;
          m_st = 3;
        end else begin
          m_oor = 1; m_st = 3;
        end
      end
      3: if (tick) begin
        m_ticks++;
        if (m_ticks == HOLD) begin
          m_keys.delete(); m_end_turn();
        end
      end
      default: m_st = 0;
    endcase
    if (m_st != old_st || m_pl != old_pl) m_ticks = 0;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_st));
    check("player", 32'(player), 32'(m_pl));
    check("guess_bcd", 32'(guess_bcd), 32'(m_guess()));
    check("left", 32'(left), 32'(m_left));
    check("right", 32'(right), 32'(m_right));
    check("attempts0", 32'(attempts0), 32'(m_att[0]));
    check("attempts1", 32'(attempts1), 32'(m_att[1]));
    check("winner", 32'(winner), 32'(m_win));
    check("pulses", 32'({hit, out_of_range, timeout}), 32'({m_hit, m_oor, m_to}));
  endtask

  // driver tasks: one clock per call with the currently driven inputs
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    rst = 0; tick = 0; start = 0; digit_valid = 0; enter = 0; clear = 0;
  endtask

  task automatic do_start(input int s);
    start = 1; secret = 7'(s); cyc();
  endtask

  task automatic key(input int d);
    digit_valid = 1; digit = 4'(d); cyc();
  endtask

  task automatic press_enter();
    enter = 1; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; cyc();
    end
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; secret = 0; digit_valid = 0; digit = 0; enter = 0; clear = 0;
    cyc();
    check("rst_state", 32'(state), 0);
    check("rst_guess", 32'(guess_bcd), 32'h0BB);
    check("rst_right", 32'(right), 99);

    do_start(42);
    check("start_state", 32'(state), 1);
    check("start_bounds", 32'({left, right}), 32'({7'd0, 7'd99}));

    key(3); key(0); press_enter();
    check("check_state", 32'(state), 2);
    cyc();
    check("p0_att", 32'(attempts0), 1);
    check("p0_left", 32'(left), 30);
    ticks(HOLD);
    check("turn_p1", 32'(player), 1);
    check("turn_blank", 32'(guess_bcd), 32'h0BB);

    key(5); key(0); key(7);
    check("guess07", 32'(guess_bcd), 32'h007);
    press_enter(); cyc();
    check("oor_pulse", 32'(out_of_range), 1);
    check("oor_bounds", 32'({left, right}), 32'({7'd30, 7'd99}));
    check("p1_att", 32'(attempts1), 1);
    ticks(HOLD);

    key(4); key(2); press_enter(); cyc();
    check("hit_pulse", 32'(hit), 1);
    check("hit_bounds", 32'({left, right}), 32'({7'd42, 7'd42}));
    check("hit_winner", 32'(winner), 1);
    do_start(0);
    check("bad_start", 32'(state), 4);

    do_start(50);
    for (int t = 0; t < 2 * MAXA; t++) begin
      key(1); press_enter(); cyc(); ticks(HOLD);
    end
    check("draw_winner", 32'(winner), 3);
    check("draw_state", 32'(state), 4);

    do_start(60);
    key(5);
    digit_valid = 1; digit = 7; clear = 1; cyc();
    check("clear_prio", 32'(guess_bcd), 32'h0BB);

`ifdef GUESS_TIMEOUT_EN
    ticks(TMO);
    check("to_pulse", 32'(timeout), 1);
    check("to_att", 32'(attempts0), 1);
    check("to_player", 32'(player), 1);
`else
    ticks(100);
    check("no_timeout", 32'(state), 1);
`endif

    // random play
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) rst = 1;
      if ($urandom_range(0, 5) == 0) tick = 1;
      if ((m_st == 0 || m_st == 4) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0)) begin
        start = 1;
        secret = 7'($urandom_range(0, 110));
      end
      if ($urandom_range(0, 3) == 0) begin
        digit_valid = 1;
        if ($urandom_range(0, 1) == 0)
          digit = 4'((m_keys.size() == 0) ? (m_sec / 10) : (m_sec % 10));
        else
          digit = 4'($urandom_range(0, 11));
      end
      if ($urandom_range(0, 9) == 0) enter = 1;
      if ($urandom_range(0, 29) == 0) clear = 1;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/guess_turn_ctrl.md
Name: guess_turn_ctrl

Overview:
- Controller that sequences the number-guessing judge datapath for two players who share one keyboard and one 4-digit display.
- Collects keypad digits into a BCD guess and launches one compare per turn.
- Narrows the [left,right] window, counts attempts per player, alternates turns, and declares a winner or a draw.
- Sits between KeyboardDecoder and display_choose; it is fed by random for the secret and a clock_divider tick.

Parameters:
- MAX_ATTEMPTS, 7, attempts allowed per player (1..15).
- HOLD_TICKS, 4, ticks the RESULT state is held before the turn passes.
- TIMEOUT_TICKS, 40, ticks allowed in ENTRY before the turn is forfeited (only with GUESS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk slow enable pulse
- start  in  1  one-clk pulse: start a new game
- secret  in  7  target number, sampled on an accepted start
- digit_valid  in  1  one-clk pulse: digit is valid
- digit  in  4  keypad digit 0..9
- enter  in  1  one-clk pulse: submit guess
- clear  in  1  one-clk pulse: erase guess
- state  out  3  IDLE=0, ENTRY=1, CHECK=2, RESULT=3, DONE=4
- player  out  1  active player
- guess_bcd  out  8  {tens,ones}; 4'hB = blank
- left  out  7  lower bound
- right  out  7  upper bound
- attempts0  out  4  player 0 attempt count
- attempts1  out  4  player 1 attempt count
- winner  out  2  00 none, 01 p0, 10 p1, 11 draw
- hit  out  1  one-clk pulse on correct guess
- out_of_range  out  1  one-clk pulse when a guess is not strictly inside (left,right)
- timeout  out  1  one-clk pulse on a forfeited turn

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, player=0, guess_bcd=8'hBB, left=0, right=99, attempts=0, winner=00, all pulses 0, internal secret=0, counters=0.
- IDLE:
  - start with 1<=secret<=98: latch secret; left=0, right=99; attempts cleared; player=0; winner=00; go to ENTRY next cycle.
  - start with secret=0 or secret>=99 is ignored and the block stays in IDLE.
- ENTRY:
  - digit_valid with digit<=9: guess_bcd <= {guess_bcd[3:0],digit}; digit count saturates at 2. digit>9 is ignored.
  - clear: guess_bcd=8'hBB, count=0.
  - enter with count>=1: go to CHECK. enter with count=0 is ignored.
  - Priority within one cycle: clear > enter > digit_valid. The lower-priority inputs in that cycle are dropped.
- CHECK (exactly 1 cycle):
  - value = tens*10 + ones, with a blank digit treated as 0. Width is 7 bits; the maximum value is 99.
  - Increment attempts[player] (saturating at 15).
  - value==secret: left=right=secret, winner=player+1, hit=1, go to DONE.
  - left<value<right: if value<secret then left=value, else right=value. Go to RESULT.
  - Otherwise: bounds unchanged, out_of_range=1, go to RESULT.
- RESULT:
  - Count tick pulses. On the HOLD_TICKS-th tick: guess_bcd=8'hBB, count=0, then evaluate:
    - If both attempts >= MAX_ATTEMPTS: winner=11, go to DONE.
    - Else if the other player has attempts < MAX_ATTEMPTS: toggle player.
    - Else keep the current player.
    - In both non-DONE cases, go to ENTRY.
- DONE:
  - Outputs hold.
  - start behaves as in IDLE, including the secret check; the game restarts directly into ENTRY.
- start in ENTRY, CHECK, or RESULT is ignored.
- The tick counter clears on every state entry.
- rst at any cycle overrides all inputs; the next cycle shows the reset values.
- Latency: enter to CHECK is 1 clk; CHECK to RESULT/DONE is 1 clk; all outputs are registered.

Optional Feature:
- Macro: GUESS_TIMEOUT_EN.
- Defined:
  - In ENTRY, ticks are counted.
  - When the count reaches TIMEOUT_TICKS: timeout=1 for one clk; attempts[player]++ (saturating); guess_bcd=8'hBB; then apply the same exhaustion and turn-switch rule as the end of RESULT, without passing through CHECK.
  - The tick count restarts on each digit_valid, clear, or turn change.
- Undefined:
  - No tick counter in ENTRY.
  - timeout is tied to 0.
  - ENTRY waits indefinitely.

Test Plan:
- Reset, then start with secret=42 -> state=1, left=0, right=99, guess_bcd=BB, player=0.
- Keys 3 then 0, then enter -> CHECK: attempts0=1, left=30, right=99. After 4 ticks: player=1, guess_bcd=BB.
- Player 1 keys 5,0,7 then enter (guess_bcd=07) -> out_of_range pulse, bounds 30/99 unchanged, attempts1=1.
- Player 0 keys 4,2 then enter -> hit pulse, left=right=42, winner=01, state=4. A later start with secret=0 is ignored.
- With MAX_ATTEMPTS=1, two misses -> winner=11, state=4. digit_valid and clear in the same cycle -> guess_bcd=BB.
- With GUESS_TIMEOUT_EN and TIMEOUT_TICKS=3: 3 ticks with no key -> timeout pulse, attempts0=1, player=1. Without the macro -> still in ENTRY after 100 ticks.
